tff_stream_ctrl: RTL

Word-serial controller for the team's two-T-flip-flop sequential machine (state bits A, B; input x; output y = A ^ B). It accepts a W-bit word over a valid/ready handshake and feeds it into the machine MSB-first, one bit per clock. It collects the y stream into a result word and returns that word with the final machine state over a second valid/ready handshake. It sits between a host-side word interface and the bit-serial sequential circuit, and it owns the only copy of A and B.

---
 rtl/tff_stream_pkg.sv | 14 +
 rtl/tff_step_core.sv | 41 ++++
 rtl/tff_stream_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/tff_stream_pkg.sv
// Shared types and constants for the word-serial T-flip-flop stream controller.
package tff_stream_pkg;

   // Default word width in bits.
   localparam int unsigned TffDefaultW = 8;

   // Controller states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } tff_state_e;

endpackage

// File: rtl/tff_step_core.sv
// Two-T-flip-flop sequential machine: state bits A, B; input x; output y = A ^ B.
// Steps only when step is high; clear forces A = B = 0 and wins over step.
module tff_step_core (
   input  logic clk,
   input  logic reset_n,
   input  logic x,
   input  logic step,
   input  logic clear,
   output logic a,
   output logic b,
   output logic y
);

   logic a_q, b_q;
   logic t_a, t_b;

   // Toggle inputs and output from the current (pre-edge) state.
   always_comb begin
      t_a = (~a_q & x) | (b_q & ~x);
      t_b = (a_q & ~b_q) | (~a_q & x);
      y   = a_q ^ b_q;
   end

   // State bits: asynchronous reset, synchronous clear, toggle on step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q <= 1'b0;
         b_q <= 1'b0;
      end else if (clear) begin
         a_q <= 1'b0;
         b_q <= 1'b0;
      end else if (step) begin
         a_q <= a_q ^ t_a;
         b_q <= b_q ^ t_b;
      end
   end

   assign a = a_q;
   assign b = b_q;

endmodule

// File: rtl/tff_stream_ctrl.sv
// Word-serial controller: accepts a W-bit word, feeds it MSB-first into the
// T-flip-flop machine one bit per clock, collects the y stream and returns it
// with the final machine state.
module tff_stream_ctrl
   import tff_stream_pkg::*;
#(
   parameter int unsigned W = TffDefaultW
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_clr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   out_state,
   output logic         busy
);

   localparam int unsigned CntW = $clog2(W);

   tff_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    sreg_q, sreg_d;
   logic [W-1:0]    res_q, res_d;

   logic core_x, core_step, core_clear;
   logic core_a, core_b, core_y;

   tff_step_core u_core (
      .clk     (clk),
      .reset_n (reset_n),
      .x       (core_x),
      .step    (core_step),
      .clear   (core_clear),
      .a       (core_a),
      .b       (core_b),
      .y       (core_y)
   );

   // The machine always sees the MSB of the input shift register.
   assign core_x = sreg_q[W-1];

   // Next-state, datapath updates and pure state-decoded handshake outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sreg_d     = sreg_q;
      res_d      = res_q;
      core_step  = 1'b0;
      core_clear = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sreg_d     = in_data;
               cnt_d      = CntW'(W - 1);
               core_clear = in_clr;
               state_d    = StShift;
            end
         end
         StShift: begin
            busy      = 1'b1;
            core_step = 1'b1;
            sreg_d    = {sreg_q[W-2:0], 1'b0};
            res_d     = {res_q[W-2:0], core_y};
            if (cnt_q == '0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDone: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sreg_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         res_q   <= res_d;
      end
   end

   assign out_data  = res_q;
   assign out_state = {core_a, core_b};

endmodule
